// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and baud tick helper.
`timescale 1ns/1ps
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_t;

   localparam int DATA_BITS = 8;

   function automatic int calc_ticks(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-bit 2-FF synchroniser for asynchronous inputs; RST_VAL sets each bit's reset level.
`timescale 1ns/1ps
module uart_sync #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic meta_reg;
         logic sync_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               meta_reg <= RST_VAL[gi];
               sync_reg <= RST_VAL[gi];
            end else begin
               meta_reg <= d[gi];
               sync_reg <= meta_reg;
            end
         end

         assign q[gi] = sync_reg;
      end
   endgenerate

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 with even parity checking.
`timescale 1ns/1ps
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK  = 50000000,
   parameter int BAUD = 115200
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       rx_i,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   output logic       frame_err_o,
   output logic       parity_err_o,
   output logic       idle_o
);

   localparam int BIT_TICKS  = calc_ticks(CLK, BAUD);
   localparam int HALF_TICKS = BIT_TICKS / 2;
   localparam int CNT_W      = $clog2(BIT_TICKS);
   localparam int IDX_W      = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TICKS - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TICKS - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

   logic rx_s;

   uart_sync #(
      .WIDTH   (1),
      .RST_VAL (1'b1)
   ) u_sync (
      .clk   (clk_i),
      .rst_n (rst_n_i),
      .d     (rx_i),
      .q     (rx_s)
   );

   uart_state_t          state_reg, state_next;
   logic [CNT_W-1:0]     tick_reg, tick_next;
   logic [IDX_W-1:0]     idx_reg, idx_next;
   logic [DATA_BITS-1:0] shift_reg, shift_next;
   logic [7:0]           data_reg, data_next;
   logic                 valid_reg, valid_next;
   logic                 ferr_reg, ferr_next;
`ifdef UART_RX_PARITY_EN
   logic                 parity_reg, parity_next;
   logic                 perr_reg, perr_next;
`endif
   logic                 sample;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_reg  <= IDLE;
         tick_reg   <= '0;
         idx_reg    <= '0;
         shift_reg  <= '0;
         data_reg   <= 8'h00;
         valid_reg  <= 1'b0;
         ferr_reg   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_reg <= 1'b0;
         perr_reg   <= 1'b0;
`endif
      end else begin
         state_reg  <= state_next;
         tick_reg   <= tick_next;
         idx_reg    <= idx_next;
         shift_reg  <= shift_next;
         data_reg   <= data_next;
         valid_reg  <= valid_next;
         ferr_reg   <= ferr_next;
`ifdef UART_RX_PARITY_EN
         parity_reg <= parity_next;
         perr_reg   <= perr_next;
`endif
      end
   end

   always_comb begin
      state_next  = state_reg;
      tick_next   = tick_reg + CNT_W'(1);
      idx_next    = idx_reg;
      shift_next  = shift_reg;
      data_next   = data_reg;
      valid_next  = 1'b0;
      ferr_next   = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_next = parity_reg;
      perr_next   = 1'b0;
`endif
      // START waits only half a bit so every later sample lands mid-bit
      sample = (state_reg == START) ? (tick_reg == HALF_LAST) : (tick_reg == BIT_LAST);
      if (sample) begin
         tick_next = '0;
      end

      case (state_reg)
         IDLE: begin
            tick_next = '0;
            if (!rx_s) begin
               state_next = START;
            end
         end
         START: begin
            if (sample) begin
               if (!rx_s) begin
                  state_next = DATA;
                  idx_next   = '0;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         DATA: begin
            if (sample) begin
               shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
               idx_next   = idx_reg + IDX_W'(1);
               if (idx_reg == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (sample) begin
               parity_next = rx_s;
               state_next  = STOP;
            end
         end
`endif
         STOP: begin
            if (sample) begin
               state_next = IDLE;
               if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                  if (^{shift_reg, parity_reg}) begin
                     perr_next = 1'b1;
                  end else begin
                     data_next  = shift_reg;
                     valid_next = 1'b1;
                  end
`else
                  data_next  = shift_reg;
                  valid_next = 1'b1;
`endif
               end else begin
                  ferr_next = 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign rx_data_o   = data_reg;
   assign rx_valid_o  = valid_reg;
   assign frame_err_o = ferr_reg;
   assign idle_o      = (state_reg == IDLE);
`ifdef UART_RX_PARITY_EN
   assign parity_err_o = perr_reg;
`else
   assign parity_err_o = 1'b0;
`endif

endmodule
